// File: rtl/cpld_io_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | cpld_link_pkg                                                              |
// | Shared frame layout constants for the FPGA<->CPLD serial I/O link.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpld_link_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LED_LSB    = 0;
  localparam int DISP_LSB   = 8;

  localparam int TX_DIP_LSB = 1;
  localparam int TX_NAV_LSB = 9;
  localparam int TX_SEL_BIT = 14;

  localparam logic [1:0] DIG_N_OFF   = 2'b11;
  localparam logic [1:0] DIG_N_DISP1 = 2'b10;
  localparam logic [1:0] DIG_N_DISP2 = 2'b01;

  // Return word: bit 15 and bit 0 are always zero.
  function automatic logic [FRAME_BITS-1:0] pack_tx(input logic       sel,
                                                    input logic [4:0] nav,
                                                    input logic [7:0] dip);
    logic [FRAME_BITS-1:0] tx;
    tx                     = '0;
    tx[TX_SEL_BIT]         = sel;
    tx[TX_NAV_LSB +: 5]    = nav;
    tx[TX_DIP_LSB +: 8]    = dip;
    return tx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpld_sync_edge.sv
// +----------------------------------------------------------------------------+
// | cpld_sync_edge                                                             |
// | Multi-stage synchronizer with optional rise/fall detection on bit 0.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpld_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise,
  output logic             fall
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

  generate
    if (EDGES) begin : g_edge
      logic r_hist;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hist <= 1'b0;
        end else begin
          r_hist <= q[0];
        end
      end

      assign rise = q[0] & ~r_hist;
      assign fall = ~q[0] & r_hist;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cpld_io_responder.sv
// +----------------------------------------------------------------------------+
// | cpld_io_responder                                                          |
// | CPLD-side responder: receives LED/display frames, returns switch state.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpld_io_responder
  import cpld_link_pkg::*;
#(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic       Bus2IP_Clk,
  input  logic       Bus2IP_Resetn,
  input  logic       cpld_clk,
  input  logic       cpld_load,
  input  logic       cpld_mosi,
  output logic       cpld_miso,
  input  logic [7:0] dip_in,
  input  logic [4:0] nav_in,
  output logic [7:0] led_out,
  output logic [7:0] seg_out,
  output logic [1:0] dig_n,
  output logic       frame_valid,
  output logic       frame_err
);

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_unused_clk_lvl;
  logic [14:0]           w_data_s;
  logic                  w_unused_data_rise;
  logic                  w_unused_data_fall;
  logic                  w_load_s;
  logic                  w_mosi_s;
  logic [7:0]            w_dip_s;
  logic [4:0]            w_nav_s;
  logic [FRAME_BITS-1:0] w_word;
  logic                  w_commit;

  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_tx_shr;
  logic [3:0]            r_bit_cnt;
  logic                  r_dig_req;
  logic                  r_scan;
  logic                  r_lit;
  logic [7:0]            r_disp1;
  logic [7:0]            r_disp2;

  cpld_sync_edge #(
    .WIDTH  (1),
    .STAGES (C_SYNC_STAGES),
    .EDGES  (1'b1)
  ) u_clk_sync (
    .clk   (Bus2IP_Clk),
    .rst_n (Bus2IP_Resetn),
    .d     (cpld_clk),
    .q     (w_unused_clk_lvl),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Data shares the clock's depth so mosi/load stay aligned with the edge.
  cpld_sync_edge #(
    .WIDTH  (15),
    .STAGES (C_SYNC_STAGES),
    .EDGES  (1'b0)
  ) u_data_sync (
    .clk   (Bus2IP_Clk),
    .rst_n (Bus2IP_Resetn),
    .d     ({nav_in, dip_in, cpld_mosi, cpld_load}),
    .q     (w_data_s),
    .rise  (w_unused_data_rise),
    .fall  (w_unused_data_fall)
  );

  assign w_load_s = w_data_s[0];
  assign w_mosi_s = w_data_s[1];
  assign w_dip_s  = w_data_s[9:2];
  assign w_nav_s  = w_data_s[14:10];

  assign w_word   = {w_mosi_s, r_rx[FRAME_BITS-1:1]};
  assign w_commit = (r_bit_cnt == 4'(FRAME_BITS - 1));

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_rx        <= '0;
      r_tx_shr    <= '0;
      r_bit_cnt   <= '0;
      r_dig_req   <= 1'b0;
      r_scan      <= 1'b0;
      r_lit       <= 1'b0;
      r_disp1     <= '0;
      r_disp2     <= '0;
      led_out     <= '0;
      seg_out     <= '0;
      dig_n       <= DIG_N_OFF;
      cpld_miso   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (w_rise) begin
        r_rx <= w_word;
        if (w_load_s) begin
          r_bit_cnt <= '0;
          // Select bit reflects dig_req after this frame's toggle (if any).
          r_tx_shr  <= pack_tx(w_commit ? ~r_dig_req : r_dig_req, w_nav_s, w_dip_s);
          if (w_commit) begin
            led_out <= w_word[LED_LSB +: 8];
            if (r_dig_req) begin
              r_disp1 <= w_word[DISP_LSB +: 8];
            end else begin
              r_disp2 <= w_word[DISP_LSB +: 8];
            end
            r_dig_req   <= ~r_dig_req;
            r_scan      <= ~r_scan;
            r_lit       <= 1'b1;
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (w_fall) begin
        cpld_miso <= r_tx_shr[0];
        r_tx_shr  <= {1'b0, r_tx_shr[FRAME_BITS-1:1]};
      end

      // Digits stay blanked until the first frame has been committed.
      if (r_lit) begin
        dig_n   <= r_scan ? DIG_N_DISP2 : DIG_N_DISP1;
        seg_out <= r_scan ? r_disp2 : r_disp1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpld_io_responder.sv
// +----------------------------------------------------------------------------+
// | tb_cpld_io_responder                                                       |
// | Directed self-checking bench for the CPLD I/O responder.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpld_io_responder;

  localparam int HALF = 10;

  logic       clk;
  logic       rst_n;
  logic       cpld_clk;
  logic       cpld_load;
  logic       cpld_mosi;
  logic       cpld_miso;
  logic [7:0] dip_in;
  logic [4:0] nav_in;
  logic [7:0] led_out;
  logic [7:0] seg_out;
  logic [1:0] dig_n;
  logic       frame_valid;
  logic       frame_err;

  int n_cmp;
  int n_err;
  int cnt_v;
  int cnt_e;
  int v0;
  int e0;
  logic [15:0] rb;

  cpld_io_responder #(.C_SYNC_STAGES(2)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .cpld_clk      (cpld_clk),
    .cpld_load     (cpld_load),
    .cpld_mosi     (cpld_mosi),
    .cpld_miso     (cpld_miso),
    .dip_in        (dip_in),
    .nav_in        (nav_in),
    .led_out       (led_out),
    .seg_out       (seg_out),
    .dig_n         (dig_n),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) cnt_v++;
    if (frame_err)   cnt_e++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit period: falling edge with new data, then rising edge; miso sampled late in high phase.
  task automatic send_bit(input logic b, input logic ld, output logic miso_bit);
    cpld_clk  = 1'b0;
    cpld_mosi = b;
    cpld_load = ld;
    repeat (HALF) @(posedge clk);
    cpld_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 miso_bit = cpld_miso;
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, output logic [15:0] miso_w);
    logic mb;
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[i], (i == nbits - 1), mb);
      miso_w[i] = mb;
    end
  endtask

  initial begin
    #50ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mb;
    n_cmp = 0; n_err = 0; cnt_v = 0; cnt_e = 0;
    rst_n = 1'b0; cpld_clk = 1'b0; cpld_load = 1'b0; cpld_mosi = 1'b0;
    dip_in = 8'h81; nav_in = 5'h15;
    repeat (5) @(posedge clk);
    #1;
    check("rst_led",  led_out, 8'h00);
    check("rst_seg",  seg_out, 8'h00);
    check("rst_dign", dig_n, 2'b11);
    check("rst_miso", cpld_miso, 1'b0);
    check("rst_fv",   frame_valid, 1'b0);
    check("rst_fe",   frame_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Frame 1: disp2 <= A5, scan -> 1
    v0 = cnt_v; e0 = cnt_e;
    send_frame(16'hA53C, 16, rb);
    check("f1_led",  led_out, 8'h3C);
    check("f1_fv",   cnt_v - v0, 1);
    check("f1_fe",   cnt_e - e0, 0);
    check("f1_dign", dig_n, 2'b01);
    check("f1_seg",  seg_out, 8'hA5);

    // Frame 2: disp1 <= 11, scan -> 0; returns switches captured at frame 1
    dip_in = 8'h5A; nav_in = 5'h0A;
    send_frame(16'h11C3, 16, rb);
    check("f2_readback", rb, 16'h6B02);
    check("f2_led",  led_out, 8'hC3);
    check("f2_dign", dig_n, 2'b10);
    check("f2_seg",  seg_out, 8'h11);

    // Frame 3: disp2 <= 22, scan -> 1; select bit was 0 after frame 2
    send_frame(16'h2277, 16, rb);
    check("f3_readback", rb, 16'h14B4);
    check("f3_led",  led_out, 8'h77);
    check("f3_dign", dig_n, 2'b01);
    check("f3_seg",  seg_out, 8'h22);

    // Short frame: load on bit 10
    dip_in = 8'hFF; nav_in = 5'h1F;
    v0 = cnt_v; e0 = cnt_e;
    send_frame(16'h03FF, 10, rb);
    check("short_fe",   cnt_e - e0, 1);
    check("short_fv",   cnt_v - v0, 0);
    check("short_led",  led_out, 8'h77);
    check("short_dign", dig_n, 2'b01);
    check("short_seg",  seg_out, 8'h22);

    // Recovery frame: disp1 <= 44, scan -> 0; readback from the error capture
    v0 = cnt_v; e0 = cnt_e;
    send_frame(16'h4412, 16, rb);
    check("rec_readback", rb, 16'h7FFE);
    check("rec_fv",   cnt_v - v0, 1);
    check("rec_fe",   cnt_e - e0, 0);
    check("rec_led",  led_out, 8'h12);
    check("rec_dign", dig_n, 2'b10);
    check("rec_seg",  seg_out, 8'h44);

    // Reset mid-frame after bit 7
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, mb);
    check("mid_miso_pre", mb, 1'b1);
    cpld_clk = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_led",  led_out, 8'h00);
    check("mid_seg",  seg_out, 8'h00);
    check("mid_dign", dig_n, 2'b11);
    check("mid_miso", cpld_miso, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    v0 = cnt_v; e0 = cnt_e;
    send_frame(16'h5AA5, 16, rb);
    check("post_fv",   cnt_v - v0, 1);
    check("post_fe",   cnt_e - e0, 0);
    check("post_led",  led_out, 8'hA5);
    check("post_dign", dig_n, 2'b01);
    check("post_seg",  seg_out, 8'h5A);

    // Load held across a second rising edge
    v0 = cnt_v; e0 = cnt_e;
    send_bit(1'b0, 1'b1, mb);
    check("hold_fe",  cnt_e - e0, 1);
    check("hold_fv",  cnt_v - v0, 0);
    check("hold_led", led_out, 8'hA5);

    // Idle with cpld_clk high
    v0 = cnt_v; e0 = cnt_e;
    repeat (10000) @(posedge clk);
    #1;
    check("idle_fv",   cnt_v - v0, 0);
    check("idle_fe",   cnt_e - e0, 0);
    check("idle_led",  led_out, 8'hA5);
    check("idle_dign", dig_n, 2'b01);
    check("idle_seg",  seg_out, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
